// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared definitions for the compy CPU-side bus controller.
//   - FSM state and read-source encodings
//   - SYS control register bit positions
//   - default compy region tables (base / mask / read wait states)
package sys_bus_pkg;

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   // Source latched at the start of a read, selects what is returned at completion.
   typedef enum logic [1:0] {
      SRC_SLAVE,
      SRC_SYS,
      SRC_UNMAPPED
   } src_t;

   // SYS register layout: speed LSB-aligned, sticky bus error in the MSB.
   localparam int unsigned SYS_SPEED_LSB = 0;

   function automatic int unsigned sys_err_bit(input int unsigned data_w);
      return data_w - 1;
   endfunction

   // Default compy memory map (index 0 is highest priority):
   //   0 RAM    0000-7FFF  0 wait
   //   1 ROM    C000-FFFF  2 wait
   //   2 IO     9000-90FF  1 wait
   //   3 CHRONI 9100-91FF  3 wait
   //   4 EXT    8000-8FFF  5 wait
   localparam logic [5*16-1:0] COMPY_REGION_BASE =
      {16'h8000, 16'h9100, 16'h9000, 16'hC000, 16'h0000};
   localparam logic [5*16-1:0] COMPY_REGION_MASK =
      {16'hF000, 16'hFF00, 16'hFF00, 16'hC000, 16'h8000};
   localparam logic [5*4-1:0]  COMPY_REGION_WAIT =
      {4'd5, 4'd3, 4'd1, 4'd2, 4'd0};

endpackage

// File: rtl/bus_decode.sv
// bus_decode: combinational address decoder.
//   addr     in   CPU (or DMA) address
//   sel      out  one-hot region select, all zero for SYS_ADDR or unmapped
//   idx      out  index of the winning region (lowest index wins)
//   hit_sys  out  address equals SYS_ADDR (overrides every region)
//   unmapped out  no region and not SYS_ADDR
module bus_decode #(
   parameter int unsigned                   ADDR_W      = 16,
   parameter int unsigned                   NUM_SLAVES  = 5,
   parameter int unsigned                   IDX_W       = 3,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]  REGION_BASE = '0,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]  REGION_MASK = '0,
   parameter logic [ADDR_W-1:0]             SYS_ADDR    = '0
) (
   input  logic [ADDR_W-1:0]     addr,
   output logic [NUM_SLAVES-1:0] sel,
   output logic [IDX_W-1:0]      idx,
   output logic                  hit_sys,
   output logic                  unmapped
);

   logic hit;

   always_comb begin
      sel     = '0;
      idx     = '0;
      hit     = 1'b0;
      hit_sys = (addr == SYS_ADDR);
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (!hit && ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                      (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W]))) begin
            hit    = 1'b1;
            idx    = IDX_W'(i);
            sel[i] = 1'b1;
         end
      end
      if (hit_sys) sel = '0;
      unmapped = !hit_sys && !hit;
   end

endmodule

// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl: CPU-side bus controller for compy.
//   sys_clk, reset_n        clock, synchronous active-low reset
//   cpu_addr/rd_req/wr_*    CPU bus; a read starts on the rising edge of cpu_rd_req
//   cpu_rd_data, cpu_ready  registered read data and CPU stall (0 = stall)
//   cpu_clk_en              throttled CPU clock-enable pulse
//   slv_sel, slv_wr_en      one-hot slave select / write strobe
//   slv_rd_data             packed slave read data
//   speed, bus_err          SYS register contents
module sys_bus_ctrl
   import sys_bus_pkg::*;
#(
   parameter int unsigned                  ADDR_W      = 16,
   parameter int unsigned                  DATA_W      = 8,
   parameter int unsigned                  NUM_SLAVES  = 5,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = COMPY_REGION_BASE,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_MASK = COMPY_REGION_MASK,
   parameter logic [NUM_SLAVES*4-1:0]      REGION_WAIT = COMPY_REGION_WAIT,
   parameter logic [ADDR_W-1:0]            SYS_ADDR    = 16'h9300,
   parameter int unsigned                  SPEED_W     = 3,
   parameter int unsigned                  SPEED_MAX   = 4,
   parameter logic [SPEED_W-1:0]           SPEED_RST   = '0
) (
   input  logic                         sys_clk,
   input  logic                         reset_n,
   input  logic [ADDR_W-1:0]            cpu_addr,
   input  logic                         cpu_rd_req,
   input  logic                         cpu_wr_en,
   input  logic [DATA_W-1:0]            cpu_wr_data,
   output logic [DATA_W-1:0]            cpu_rd_data,
   output logic                         cpu_ready,
   output logic                         cpu_clk_en,
   output logic [NUM_SLAVES-1:0]        slv_sel,
   output logic [NUM_SLAVES-1:0]        slv_wr_en,
   input  logic [NUM_SLAVES*DATA_W-1:0] slv_rd_data,
   output logic [SPEED_W-1:0]           speed,
   output logic                         bus_err
);

   localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned DIV_W = SPEED_MAX + 1;

   logic [NUM_SLAVES-1:0] dec_sel;
   logic [IDX_W-1:0]      dec_idx;
   logic                  dec_sys, dec_unmapped;

   bus_decode #(
      .ADDR_W      (ADDR_W),
      .NUM_SLAVES  (NUM_SLAVES),
      .IDX_W       (IDX_W),
      .REGION_BASE (REGION_BASE),
      .REGION_MASK (REGION_MASK),
      .SYS_ADDR    (SYS_ADDR)
   ) u_decode (
      .addr     (cpu_addr),
      .sel      (dec_sel),
      .idx      (dec_idx),
      .hit_sys  (dec_sys),
      .unmapped (dec_unmapped)
   );

   state_t             state_q, state_d;
   src_t               src_q, src_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               err_q, err_d;
   logic               rd_req_prev_q, rd_req_prev_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               clk_en_q, clk_en_d;

   logic              rd_edge, wr_ok, err_set, err_clr;
   logic [DATA_W-1:0] sys_word;
   logic [DIV_W-1:0]  div_mask;
   int unsigned       eff;

   assign rd_edge = cpu_rd_req && !rd_req_prev_q;
   assign wr_ok   = cpu_wr_en && (state_q == IDLE);

   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      ready_d       = ready_q;
      rd_data_d     = rd_data_q;
      speed_d       = speed_q;
      err_d         = err_q;
      rd_req_prev_d = cpu_rd_req;
      err_set       = 1'b0;
      err_clr       = 1'b0;
      sys_word      = '0;
      sys_word[SYS_SPEED_LSB +: SPEED_W] = speed_q;
      sys_word[sys_err_bit(DATA_W)]      = err_q;

      // Writes never stall; one arriving mid-read is dropped and flagged.
      if (cpu_wr_en && (state_q == WAIT)) err_set = 1'b1;
      if (wr_ok && dec_sys)               speed_d = cpu_wr_data[SPEED_W-1:0];
      if (wr_ok && dec_unmapped)          err_set = 1'b1;

      case (state_q)
         IDLE: begin
            if (rd_edge) begin
               state_d = WAIT;
               ready_d = 1'b0;
               cnt_d   = '0;
               if (dec_sys) begin
                  src_d = SRC_SYS;
               end else if (dec_unmapped) begin
                  src_d = SRC_UNMAPPED;
               end else begin
                  src_d = SRC_SLAVE;
                  idx_d = dec_idx;
                  cnt_d = REGION_WAIT[dec_idx*4 +: 4];
               end
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
               ready_d = 1'b1;
               case (src_q)
                  SRC_SYS: begin
                     rd_data_d = sys_word;
                     err_clr   = 1'b1;
                  end
                  SRC_UNMAPPED: begin
                     rd_data_d = '1;
                     err_set   = 1'b1;
                  end
                  default: rd_data_d = slv_rd_data[idx_q*DATA_W +: DATA_W];
               endcase
            end
         end
         default: state_d = IDLE;
      endcase

      // A fresh error in the same cycle as a SYS read-clear keeps the flag set.
      if (err_set)      err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;
   end

   // Throttle: pulse the cycle after the low eff+1 counter bits are all ones.
   // Bit 0 of the counter must be one for a pulse, so pulses can never be adjacent.
   always_comb begin
      eff = 32'(speed_q);
      if (eff > SPEED_MAX) eff = SPEED_MAX;
      div_mask = '0;
      for (int unsigned i = 0; i < DIV_W; i++) div_mask[i] = (i <= eff);
      div_d    = div_q + 1'b1;
      clk_en_d = &(div_q | ~div_mask);
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         src_q         <= SRC_SLAVE;
         idx_q         <= '0;
         cnt_q         <= '0;
         ready_q       <= 1'b1;
         rd_data_q     <= '0;
         speed_q       <= SPEED_RST;
         err_q         <= 1'b0;
         rd_req_prev_q <= 1'b0;
         div_q         <= '0;
         clk_en_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         ready_q       <= ready_d;
         rd_data_q     <= rd_data_d;
         speed_q       <= speed_d;
         err_q         <= err_d;
         rd_req_prev_q <= rd_req_prev_d;
         div_q         <= div_d;
         clk_en_q      <= clk_en_d;
      end
   end

   assign cpu_rd_data = rd_data_q;
   assign cpu_ready   = ready_q;
   assign cpu_clk_en  = clk_en_q;
   assign slv_sel     = dec_sel;
   assign slv_wr_en   = wr_ok ? dec_sel : '0;
   assign speed       = speed_q;
   assign bus_err     = err_q;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// tb_sys_bus_ctrl: directed self-checking bench for sys_bus_ctrl.
// Test map: 0:0000-3FFF w0, 1:4000-7FFF w2, 2:0000-7FFF w1 (overlaps 0/1),
// 3:8000-8FFF w5, 4:C000-FFFF w0; 9000-BFFF other than 9300 is unmapped.
module tb_sys_bus_ctrl;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned NS     = 5;

   logic              sys_clk, reset_n;
   logic [15:0]       cpu_addr;
   logic              cpu_rd_req, cpu_wr_en;
   logic [7:0]        cpu_wr_data, cpu_rd_data;
   logic              cpu_ready, cpu_clk_en;
   logic [NS-1:0]     slv_sel, slv_wr_en;
   logic [NS*8-1:0]   slv_rd_data;
   logic [2:0]        speed;
   logic              bus_err;

   int vectors;
   int miscompares;

   sys_bus_ctrl #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .NUM_SLAVES  (NS),
      .REGION_BASE ({16'hC000, 16'h8000, 16'h0000, 16'h4000, 16'h0000}),
      .REGION_MASK ({16'hC000, 16'hF000, 16'h8000, 16'hC000, 16'hC000}),
      .REGION_WAIT ({4'd0, 4'd5, 4'd1, 4'd2, 4'd0}),
      .SYS_ADDR    (16'h9300),
      .SPEED_W     (3),
      .SPEED_MAX   (4),
      .SPEED_RST   (3'd0)
   ) dut (
      .sys_clk     (sys_clk),
      .reset_n     (reset_n),
      .cpu_addr    (cpu_addr),
      .cpu_rd_req  (cpu_rd_req),
      .cpu_wr_en   (cpu_wr_en),
      .cpu_wr_data (cpu_wr_data),
      .cpu_rd_data (cpu_rd_data),
      .cpu_ready   (cpu_ready),
      .cpu_clk_en  (cpu_clk_en),
      .slv_sel     (slv_sel),
      .slv_wr_en   (slv_wr_en),
      .slv_rd_data (slv_rd_data),
      .speed       (speed),
      .bus_err     (bus_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start a read on a rising cpu_rd_req, count stall cycles, check data.
   task automatic do_read(input string tag, input logic [15:0] a,
                          input logic [7:0] exp_data, input int exp_low);
      int n;
      cpu_addr   = a;
      cpu_rd_req = 1'b1;
      tick;
      n = 0;
      while (cpu_ready !== 1'b1 && n < 40) begin
         n++;
         tick;
      end
      chk({tag, " stall cycles"}, n, exp_low);
      chk({tag, " data"}, cpu_rd_data, exp_data);
      cpu_rd_req = 1'b0;
      tick;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr    = a;
      cpu_wr_data = d;
      cpu_wr_en   = 1'b1;
      tick;
      cpu_wr_en   = 1'b0;
   endtask

   // Skip to a pulse, skip one interval (may be shortened by a speed change),
   // then return the length of the next full interval.
   task automatic measure_period(output int p);
      int n;
      for (int k = 0; k < 2; k++) begin
         n = 0;
         while (cpu_clk_en !== 1'b1 && n < 100) begin
            tick;
            n++;
         end
         tick;
      end
      p = 1;
      while (cpu_clk_en !== 1'b1 && p < 100) begin
         tick;
         p++;
      end
   endtask

   initial begin
      int p, n, bb;
      logic prev;
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      cpu_addr    = '0;
      cpu_rd_req  = 1'b0;
      cpu_wr_en   = 1'b0;
      cpu_wr_data = '0;
      slv_rd_data = {8'h44, 8'h33, 8'h22, 8'hA5, 8'h11};

      repeat (3) tick;
      chk("rst cpu_ready", cpu_ready, 1);
      chk("rst cpu_rd_data", cpu_rd_data, 0);
      chk("rst cpu_clk_en", cpu_clk_en, 0);
      chk("rst speed", speed, 0);
      chk("rst bus_err", bus_err, 0);
      reset_n = 1'b1;
      tick;

      // Region 1, 2 wait states
      cpu_addr = 16'h4000;
      #1;
      chk("sel region1", slv_sel, 5'b00010);
      do_read("rd region1", 16'h4000, 8'hA5, 3);
      chk("bus_err after good read", bus_err, 0);

      // Unmapped read: all ones, sets bus_err
      cpu_addr = 16'hA000;
      #1;
      chk("sel unmapped", slv_sel, 5'b00000);
      do_read("rd unmapped", 16'hA000, 8'hFF, 1);
      chk("bus_err after unmapped", bus_err, 1);

      // SYS read returns {err, speed} then clears err
      cpu_addr = 16'h9300;
      #1;
      chk("sel sys", slv_sel, 5'b00000);
      do_read("rd sys", 16'h9300, 8'h80, 1);
      chk("bus_err cleared by sys read", bus_err, 0);

      // Throttle periods
      do_write(16'h9300, 8'h03);
      chk("speed=3", speed, 3);
      measure_period(p);
      chk("period speed3", p, 16);
      do_write(16'h9300, 8'h07);
      chk("speed=7", speed, 7);
      measure_period(p);
      chk("period speed7 clamped", p, 32);

      prev = 1'b0;
      bb   = 0;
      for (int i = 0; i < 80; i++) begin
         if (i == 10) begin
            cpu_addr    = 16'h9300;
            cpu_wr_data = 8'h00;
            cpu_wr_en   = 1'b1;
         end else begin
            cpu_wr_en = 1'b0;
         end
         tick;
         if (cpu_clk_en === 1'b1 && prev === 1'b1) bb++;
         prev = cpu_clk_en;
      end
      chk("no back-to-back pulses", bb, 0);
      chk("speed=0", speed, 0);
      measure_period(p);
      chk("period speed0", p, 2);

      // Overlapping regions 0 and 2: lowest index wins
      cpu_addr = 16'h1234;
      cpu_wr_en = 1'b1;
      #1;
      chk("sel overlap", slv_sel, 5'b00001);
      chk("wr_en overlap", slv_wr_en, 5'b00001);
      tick;
      cpu_wr_en = 1'b0;
      chk("bus_err after mapped write", bus_err, 0);

      // Write during WAIT is dropped and flagged; read completes normally
      cpu_addr   = 16'h8000;
      cpu_rd_req = 1'b1;
      tick;
      chk("stall begins", cpu_ready, 0);
      cpu_wr_data = 8'h55;
      cpu_wr_en   = 1'b1;
      #1;
      chk("wr_en during wait", slv_wr_en, 5'b00000);
      n = 0;
      while (cpu_ready !== 1'b1 && n < 40) begin
         n++;
         tick;
         cpu_wr_en = 1'b0;
      end
      chk("rd region3 stall cycles", n, 6);
      chk("rd region3 data", cpu_rd_data, 8'h33);
      chk("bus_err after wait write", bus_err, 1);
      cpu_rd_req = 1'b0;
      tick;

      // Reset during WAIT
      do_write(16'h9300, 8'h02);
      chk("speed=2", speed, 2);
      cpu_addr   = 16'h8000;
      cpu_rd_req = 1'b1;
      tick;
      chk("stall before reset", cpu_ready, 0);
      reset_n    = 1'b0;
      cpu_rd_req = 1'b0;
      tick;
      chk("mid-read rst cpu_ready", cpu_ready, 1);
      chk("mid-read rst speed", speed, 0);
      chk("mid-read rst cpu_clk_en", cpu_clk_en, 0);
      chk("mid-read rst bus_err", bus_err, 0);
      chk("mid-read rst cpu_rd_data", cpu_rd_data, 0);
      reset_n = 1'b1;
      tick;
      do_read("rd after reset", 16'h4000, 8'hA5, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
